// File: rtl/product_accumulator.sv
// Signed product accumulator with saturation: sums a block of products, result one cycle after the in_last transfer.
// Backpressure: the result is held in DONE and in_ready stays low until out_ready accepts it; clear aborts the block.
module product_accumulator #(
    parameter int N = 32,
    parameter int G = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_sum,
    output logic             out_sat,
    output logic [15:0]      out_count
);

    localparam int PW    = 2 * N;
    localparam int ACC_W = PW + G;
    localparam logic [PW-1:0] SUM_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] SUM_MIN = {1'b1, {(PW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t             state;
    logic               armed;
    logic [ACC_W-1:0]   acc;
    logic [15:0]        count;
    logic               ovf;
    logic               ovf_pos;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic               xfer;
    logic [ACC_W-1:0]   acc_nxt;
    logic [15:0]        count_nxt;
    logic               ovf_nxt;
    logic               ovf_pos_nxt;
    logic [ACC_W-PW:0]  acc_hi;
    logic               acc_fits;
    logic [PW-1:0]      sum_nxt;
    logic               sat_nxt;

    // armed keeps in_ready low during reset and for no longer than the first edge after release
    assign in_ready  = armed && (state != DONE);
    assign out_valid = (state == DONE);
    assign xfer      = in_valid && in_ready && !clear;

    assign prod_ext = {{G{in_prod[PW-1]}}, in_prod};
    assign add_sum  = acc + prod_ext;
    assign add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (add_sum[ACC_W-1] != acc[ACC_W-1]);

    always_comb begin
        acc_nxt     = acc;
        count_nxt   = count;
        ovf_nxt     = ovf;
        ovf_pos_nxt = ovf_pos;
        if (state == IDLE) begin
            acc_nxt     = prod_ext;
            count_nxt   = 16'd1;
            ovf_nxt     = 1'b0;
            ovf_pos_nxt = 1'b0;
        end else begin
            if (count != 16'hFFFF) begin
                count_nxt = count + 16'd1;
            end
            // once overflowed, acc is frozen and only the recorded direction matters
            if (!ovf) begin
                if (add_ovf) begin
                    ovf_nxt     = 1'b1;
                    ovf_pos_nxt = !acc[ACC_W-1];
                end else begin
                    acc_nxt = add_sum;
                end
            end
        end
    end

    assign acc_hi   = acc_nxt[ACC_W-1:PW-1];
    assign acc_fits = (&acc_hi) || !(|acc_hi);

    always_comb begin
        sum_nxt = acc_nxt[PW-1:0];
        sat_nxt = 1'b0;
        if (ovf_nxt) begin
            sum_nxt = ovf_pos_nxt ? SUM_MAX : SUM_MIN;
            sat_nxt = 1'b1;
        end else if (!acc_fits) begin
            sum_nxt = acc_nxt[ACC_W-1] ? SUM_MIN : SUM_MAX;
            sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            ovf_pos   <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else begin
            armed <= 1'b1;
            if (clear) begin
                state     <= IDLE;
                acc       <= '0;
                count     <= '0;
                ovf       <= 1'b0;
                ovf_pos   <= 1'b0;
                out_sum   <= '0;
                out_sat   <= 1'b0;
                out_count <= '0;
            end else begin
                case (state)
                    IDLE, ACC: begin
                        if (xfer) begin
                            acc     <= acc_nxt;
                            count   <= count_nxt;
                            ovf     <= ovf_nxt;
                            ovf_pos <= ovf_pos_nxt;
                            if (in_last) begin
                                state     <= DONE;
                                out_sum   <= sum_nxt;
                                out_sat   <= sat_nxt;
                                out_count <= count_nxt;
                            end else begin
                                state <= ACC;
                            end
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: table-driven blocks with a result scoreboard, plus backpressure, clear and reset sequences.
module tb_product_accumulator;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINP = 64'h8000_0000_0000_0000;
    localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_sum;
    logic        out_sat;
    logic [15:0] out_count;

    product_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] sum;
        logic        sat;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][63:0] p;
        exp_t             e;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [63:0] pq[$];
    vec_t        vecs[7];
    exp_t        got;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [63:0] s, input logic st, input logic [15:0] c);
        exp_t e;
        e.sum = s;
        e.sat = st;
        e.cnt = c;
        return e;
    endfunction

    function automatic vec_t mk_vec(input int n, input logic [63:0] p0, input logic [63:0] p1,
                                    input logic [63:0] p2, input logic [63:0] p3,
                                    input logic [63:0] s, input logic st, input logic [15:0] c);
        vec_t v;
        v.n    = 3'(n);
        v.p[0] = p0;
        v.p[1] = p1;
        v.p[2] = p2;
        v.p[3] = p3;
        v.e    = mk_exp(s, st, c);
        return v;
    endfunction

    // results are checked when the consumer handshake is visible, just after the falling edge
    always @(negedge clk) begin
        #1;
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                got = sb.pop_front();
                chk("out_sum", out_sum, got.sum);
                chk("out_sat", 64'(out_sat), 64'(got.sat));
                chk("out_count", 64'(out_count), 64'(got.cnt));
            end
        end
    end

    task automatic drive_prod(input logic [63:0] p, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_sb();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_block(input exp_t e);
        sb.push_back(e);
        for (int i = 0; i < pq.size(); i++) begin
            drive_prod(pq[i], i == pq.size() - 1);
        end
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        wait_sb();
        pq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk_vec(3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 64'd0, 64'd12, 1'b0, 16'd3);
        vecs[1] = mk_vec(2, MAXP, MAXP, 64'd0, 64'd0, MAXP, 1'b1, 16'd2);
        vecs[2] = mk_vec(1, NEG1, 64'd0, 64'd0, 64'd0, NEG1, 1'b0, 16'd1);
        vecs[3] = mk_vec(2, MINP, MINP, 64'd0, 64'd0, MINP, 1'b1, 16'd2);
        vecs[4] = mk_vec(3, MAXP, 64'd1, NEG1, 64'd0, MAXP, 1'b0, 16'd3);
        vecs[5] = mk_vec(2, 64'd100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 64'd0, 64'd0, 1'b0, 16'd2);
        vecs[6] = mk_vec(4, MINP, MAXP, 64'd1, 64'd2, 64'd2, 1'b0, 16'd4);

        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("release_in_ready_pre_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready), 64'd1);

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < int'(vecs[v].n); k++) pq.push_back(vecs[v].p[k]);
            run_block(vecs[v].e);
        end

        // overflow beyond the guard bits in the negative direction
        repeat (257) pq.push_back(MINP);
        run_block(mk_exp(MINP, 1'b1, 16'd257));

        // positive overflow must stay sticky even after large negative products
        repeat (257) pq.push_back(MAXP);
        repeat (255) pq.push_back(MINP);
        run_block(mk_exp(MAXP, 1'b1, 16'd512));

        // result held under backpressure while the next product waits
        out_ready = 1'b0;
        sb.push_back(mk_exp(64'd3, 1'b0, 16'd2));
        drive_prod(64'd1, 1'b0);
        drive_prod(64'd2, 1'b1);
        in_valid = 1'b1;
        in_prod  = 64'd9;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_sum", out_sum, 64'd3);
            chk("bp_out_count", 64'(out_count), 64'd2);
        end
        sb.push_back(mk_exp(64'd9, 1'b0, 16'd1));
        @(negedge clk);
        out_ready = 1'b1;
        drive_prod(64'd9, 1'b1);
        wait_sb();

        // clear aborts a partial block and zeroes the held result
        drive_prod(64'd50, 1'b0);
        drive_prod(64'd60, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        chk("clr_out_sum", out_sum, 64'd0);
        chk("clr_out_count", 64'(out_count), 64'd0);
        @(negedge clk);
        pq.push_back(64'd7);
        run_block(mk_exp(64'd7, 1'b0, 16'd1));

        // asynchronous reset between edges in the middle of a block
        drive_prod(64'd11, 1'b0);
        drive_prod(64'd12, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_sum", out_sum, 64'd0);
        chk("arst_out_count", 64'(out_count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pq.push_back(64'd4);
        run_block(mk_exp(64'd4, 1'b0, 16'd1));

        // count saturates instead of wrapping
        repeat (65536) pq.push_back(64'd0);
        run_block(mk_exp(64'd0, 1'b0, 16'hFFFF));

        chk("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
